// File: rtl/ahb_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_spi_pkg
//  Description : Shared constants and types for the AHB-Lite SPI master:
//                register offsets, CTRL/STATUS bit positions, engine states.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_spi_pkg;

  // Register offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_SS     = 2'd2;
  localparam logic [1:0] REG_DATA   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_CPHA    = 2;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_MSB = 15;

  // STATUS bit positions
  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_TX_OVF   = 5;
  localparam int STAT_RX_OVF   = 6;

  // Shift engine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_spi_master_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers. A push into a full
//                FIFO is accepted only when a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer update; push and pop are independent so a simultaneous pair keeps the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (w_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage array, written at the write pointer
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_spi_master
//  Description : AHB-Lite slave SPI master with TX/RX FIFOs, configurable
//                frame width, all four CPOL/CPHA modes, programmable SCLK
//                divider and NUM_SS active-low slave selects.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_spi_master #(
  parameter int FRAME_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [31:0]       HADDR,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              SPI_MISO_i,
  output logic              SPI_MOSI_o,
  output logic              SPI_CLK_o,
  output logic [NUM_SS-1:0] SPI_SS_o
);

  import ahb_spi_pkg::*;

  localparam int               EW        = $clog2(2*FRAME_W);
  localparam logic [EW-1:0]    LAST_EDGE = EW'(2*FRAME_W-1);

  // Bus pipeline and configuration
  logic [1:0]         addr_q;
  logic               wr_q;
  logic               rd_q;
  logic               en_cfg_q;
  logic               cpol_cfg_q;
  logic               cpha_cfg_q;
  logic [7:0]         div_cfg_q;
  logic [NUM_SS-1:0]  ss_q;
  logic               tx_ovf_q;
  logic               rx_ovf_q;

  // Engine
  state_e             state_q;
  state_e             state_d;
  logic               cpha_q;
  logic [7:0]         div_q;
  logic [7:0]         div_cnt_q;
  logic [EW-1:0]      edge_cnt_q;
  logic               sclk_q;
  logic               mosi_q;
  logic [FRAME_W-1:0] tx_sh_q;
  logic [FRAME_W-1:0] rx_sh_q;

  // FIFO interface
  logic [FRAME_W-1:0] tx_data;
  logic [FRAME_W-1:0] rx_data;
  logic               tx_empty;
  logic               tx_full;
  logic               rx_empty;
  logic               rx_full;

  logic               w_tx_push;
  logic               w_tx_pop;
  logic               w_rx_push;
  logic               w_rx_pop;
  logic               w_edge;
  logic               w_last;
  logic               w_sample;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  assign w_tx_push = wr_q && (addr_q == REG_DATA);
  assign w_rx_pop  = rd_q && (addr_q == REG_DATA) && !rx_empty;
  assign w_tx_pop  = (state_q == LOAD);
  assign w_rx_push = (state_q == DONE);

  assign w_edge    = (state_q == SHIFT) && (div_cnt_q == div_q);
  assign w_last    = w_edge && (edge_cnt_q == LAST_EDGE);
  // Edge counter even = leading edge; CPHA=0 samples there, CPHA=1 on trailing
  assign w_sample  = (edge_cnt_q[0] == cpha_q);

  assign HREADYOUT  = 1'b1;
  assign HRDATA     = w_rdata;
  assign SPI_CLK_o  = sclk_q;
  assign SPI_MOSI_o = mosi_q;
  assign SPI_SS_o   = (state_q == IDLE) ? {NUM_SS{1'b1}} : ~ss_q;

  assign w_unused_bits = ^{HADDR, HSIZE, HWDATA};

  sync_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (w_tx_push),
    .data_i  (HWDATA[FRAME_W-1:0]),
    .pop_i   (w_tx_pop),
    .data_o  (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  sync_fifo #(.WIDTH(FRAME_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (w_rx_push),
    .data_i  (rx_sh_q),
    .pop_i   (w_rx_pop),
    .data_o  (rx_data),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  // Address phase capture; the flags only live for the following data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else if (HSEL && HREADY) begin
      addr_q <= HADDR[3:2];
      wr_q   <= HWRITE;
      rd_q   <= !HWRITE;
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
    end
  end

  // Register writes in the data phase plus sticky overflow flags (set beats clear)
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      en_cfg_q   <= 1'b0;
      cpol_cfg_q <= 1'b0;
      cpha_cfg_q <= 1'b0;
      div_cfg_q  <= '0;
      ss_q       <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      if (wr_q && (addr_q == REG_CTRL)) begin
        en_cfg_q   <= HWDATA[CTRL_EN];
        cpol_cfg_q <= HWDATA[CTRL_CPOL];
        cpha_cfg_q <= HWDATA[CTRL_CPHA];
        div_cfg_q  <= HWDATA[CTRL_DIV_MSB:CTRL_DIV_LSB];
      end
      if (wr_q && (addr_q == REG_SS)) begin
        ss_q <= HWDATA[NUM_SS-1:0];
      end
      if (wr_q && (addr_q == REG_STATUS) && HWDATA[STAT_TX_OVF]) tx_ovf_q <= 1'b0;
      if (wr_q && (addr_q == REG_STATUS) && HWDATA[STAT_RX_OVF]) rx_ovf_q <= 1'b0;
      if (w_tx_push && tx_full && !w_tx_pop)  tx_ovf_q <= 1'b1;
      if (w_rx_push && rx_full && !w_rx_pop)  rx_ovf_q <= 1'b1;
    end
  end

  // Read mux, combinational from the registered address; zero outside a read
  always_comb begin
    w_rdata = '0;
    if (rd_q) begin
      case (addr_q)
        REG_CTRL: begin
          w_rdata[CTRL_EN]                   = en_cfg_q;
          w_rdata[CTRL_CPOL]                 = cpol_cfg_q;
          w_rdata[CTRL_CPHA]                 = cpha_cfg_q;
          w_rdata[CTRL_DIV_MSB:CTRL_DIV_LSB] = div_cfg_q;
        end
        REG_STATUS: begin
          w_rdata[STAT_TX_EMPTY] = tx_empty;
          w_rdata[STAT_TX_FULL]  = tx_full;
          w_rdata[STAT_RX_EMPTY] = rx_empty;
          w_rdata[STAT_RX_FULL]  = rx_full;
          w_rdata[STAT_BUSY]     = (state_q != IDLE);
          w_rdata[STAT_TX_OVF]   = tx_ovf_q;
          w_rdata[STAT_RX_OVF]   = rx_ovf_q;
        end
        REG_SS: begin
          w_rdata[NUM_SS-1:0] = ss_q;
        end
        default: begin
          if (!rx_empty) w_rdata[FRAME_W-1:0] = rx_data;
        end
      endcase
    end
  end

  // Engine state register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Engine next-state: frames chain back-to-back while enabled and TX has data
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_cfg_q && !tx_empty) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (w_last) state_d = DONE;
      DONE:    state_d = (en_cfg_q && !tx_empty) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath: mode/divider are frozen at LOAD, SCLK toggles every CLKDIV+1 cycles
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cpha_q     <= 1'b0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_q <= cpol_cfg_q;
        end
        LOAD: begin
          cpha_q     <= cpha_cfg_q;
          div_q      <= div_cfg_q;
          sclk_q     <= cpol_cfg_q;
          div_cnt_q  <= '0;
          edge_cnt_q <= '0;
          rx_sh_q    <= '0;
          if (!cpha_cfg_q) begin
            // CPHA=0 presents the MSB before the first edge
            mosi_q  <= tx_data[FRAME_W-1];
            tx_sh_q <= {tx_data[FRAME_W-2:0], 1'b0};
          end else begin
            tx_sh_q <= tx_data;
          end
        end
        SHIFT: begin
          if (w_edge) begin
            div_cnt_q  <= '0;
            edge_cnt_q <= edge_cnt_q + EW'(1);
            sclk_q     <= !sclk_q;
            if (w_sample) begin
              rx_sh_q <= {rx_sh_q[FRAME_W-2:0], SPI_MISO_i};
            end else begin
              mosi_q  <= tx_sh_q[FRAME_W-1];
              tx_sh_q <= {tx_sh_q[FRAME_W-2:0], 1'b0};
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_spi_master
//  Description : Self-checking bench for ahb_spi_master with an RX scoreboard,
//                an SPI pin monitor and a small mode-aware SPI slave.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_spi_master;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_SS     = 32'h8;
  localparam logic [31:0] A_DATA   = 32'hC;
  localparam logic [3:0]  SS_IDLE  = 4'hF;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic        HREADY = 1'b1;
  logic        HWRITE = 1'b0;
  logic [31:0] HADDR = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [31:0] HWDATA = '0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SPI_MISO_i;
  logic        SPI_MOSI_o;
  logic        SPI_CLK_o;
  logic [3:0]  SPI_SS_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q [$];

  // Bench-side mode and slave setup
  logic       loopback = 1'b1;
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] exp_ss = 4'hE;

  // Monitor state
  int          cyc = 0;
  int          busy_cyc = 0;
  int          ss_bad = 0;
  int          edges = 0;
  int          releases = 0;
  int          last_edge = 0;
  int          last_gap = 0;
  int          bitpos = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_act = 1'b0;
  logic [31:0] mosi_hist = '0;
  logic        slv_miso;

  assign slv_miso   = (bitpos >= 0 && bitpos < 8) ? pattern[7-bitpos] : 1'b0;
  assign SPI_MISO_i = loopback ? SPI_MOSI_o : slv_miso;

  ahb_spi_master #(.FRAME_W(8), .FIFO_DEPTH(4), .NUM_SS(4)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HWRITE     (HWRITE),
    .HADDR      (HADDR),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT),
    .SPI_MISO_i (SPI_MISO_i),
    .SPI_MOSI_o (SPI_MOSI_o),
    .SPI_CLK_o  (SPI_CLK_o),
    .SPI_SS_o   (SPI_SS_o)
  );

  always #5 HCLK = ~HCLK;

  // Pin monitor and slave, sampled mid-cycle on the falling HCLK edge
  always @(negedge HCLK) begin
    cyc       <= cyc + 1;
    prev_sclk <= SPI_CLK_o;
    prev_act  <= (SPI_SS_o != SS_IDLE);
    if (SPI_SS_o != SS_IDLE) begin
      busy_cyc <= busy_cyc + 1;
      if (SPI_SS_o != exp_ss) ss_bad <= ss_bad + 1;
      if (SPI_CLK_o != prev_sclk) begin
        edges     <= edges + 1;
        last_gap  <= cyc - last_edge;
        last_edge <= cyc;
        if ((SPI_CLK_o != m_cpol) != m_cpha) mosi_hist <= {mosi_hist[30:0], SPI_MOSI_o};
        else                                 bitpos    <= bitpos + 1;
      end
    end else begin
      bitpos <= m_cpha ? -1 : 0;
      if (prev_act) releases <= releases + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0;
    d = HRDATA;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // Queue a TX word and the RX word it is expected to produce
  task automatic send(input logic [7:0] tx, input logic [7:0] rx, input bit keep);
    ahb_write(A_DATA, {24'h0, tx});
    if (keep) sb_q.push_back({24'h0, rx});
  endtask

  task automatic read_data_sb();
    logic [31:0] d;
    logic [31:0] e;
    ahb_read(A_DATA, d);
    e = (sb_q.size() == 0) ? 32'hDEAD_BEEF : sb_q.pop_front();
    check_eq("rx_data", d, e);
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (SPI_SS_o == SS_IDLE && n < bound) begin
      @(negedge HCLK); n++;
    end
    check_eq("start_in_time", 32'(n < bound), 32'd1);
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (SPI_SS_o != SS_IDLE && n < bound) begin
      @(negedge HCLK); n++;
    end
    check_eq("end_in_time", 32'(n < bound), 32'd1);
    @(negedge HCLK); #1;
  endtask

  initial begin
    int b0, e0, r0, s0;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_sclk", 32'(SPI_CLK_o), 32'd0);
    check_eq("rst_ss", 32'(SPI_SS_o), 32'hF);
    HRESET = 1'b0;
    #1;
    check_eq("rst_mosi", 32'(SPI_MOSI_o), 32'd0);
    check_eq("rst_hrdata", HRDATA, 32'd0);
    check_eq("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    read_check("rst_status", A_STATUS, 32'h05);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    read_check("rst_ss_reg", A_SS, 32'h0);

    // Mode 0, CLKDIV=0, loopback of 0xA5
    ahb_write(A_SS, 32'h1);
    ahb_write(A_CTRL, 32'h1);
    read_check("ctrl_rb", A_CTRL, 32'h1);
    read_check("ss_rb", A_SS, 32'h1);
    b0 = busy_cyc; e0 = edges; s0 = ss_bad;
    send(8'hA5, 8'hA5, 1'b1);
    wait_start(20);
    wait_end(100);
    check_eq("m0_mosi", {24'h0, mosi_hist[7:0]}, 32'hA5);
    check_eq("m0_cycles", busy_cyc - b0, 32'd18);
    check_eq("m0_edges", edges - e0, 32'd16);
    check_eq("m0_ss_low", ss_bad - s0, 32'd0);
    read_data_sb();
    read_check("rx_empty_read", A_DATA, 32'h0);

    // Modes 1..3 against a slave returning 0x3C
    loopback = 1'b0;
    pattern  = 8'h3C;
    for (int m = 1; m < 4; m++) begin
      m_cpol = m[1];
      m_cpha = m[0];
      ahb_write(A_CTRL, {29'h0, m[0], m[1], 1'b1});
      repeat (3) @(negedge HCLK);
      check_eq("idle_sclk_pre", 32'(SPI_CLK_o), 32'(m[1]));
      send(8'h96, 8'h3C, 1'b1);
      wait_start(20);
      wait_end(100);
      check_eq("mode_mosi", {24'h0, mosi_hist[7:0]}, 32'h96);
      check_eq("idle_sclk_post", 32'(SPI_CLK_o), 32'(m[1]));
      read_data_sb();
    end

    // TX overflow with engine disabled, then 4 back-to-back frames
    loopback = 1'b1;
    m_cpol = 1'b0;
    m_cpha = 1'b0;
    ahb_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 8'(8'h11 + i), i < 4);
    read_check("tx_full_ovf", A_STATUS, 32'h26);
    b0 = busy_cyc; e0 = edges; r0 = releases;
    ahb_write(A_CTRL, 32'h1);
    wait_start(20);
    wait_end(300);
    check_eq("b2b_ss_release", releases - r0, 32'd1);
    check_eq("b2b_cycles", busy_cyc - b0, 32'd72);
    check_eq("b2b_edges", edges - e0, 32'd64);
    read_check("rx_full_status", A_STATUS, 32'h29);
    for (int i = 0; i < 4; i++) read_data_sb();
    ahb_write(A_STATUS, 32'h20);

    // RX overflow: 5 frames, no reads
    for (int i = 0; i < 5; i++) send(8'(8'h21 + i), 8'(8'h21 + i), i < 4);
    wait_start(20);
    wait_end(400);
    read_check("rx_ovf_status", A_STATUS, 32'h49);
    ahb_write(A_STATUS, 32'h40);
    read_check("rx_ovf_clear", A_STATUS, 32'h09);
    for (int i = 0; i < 4; i++) read_data_sb();
    read_check("rx_drained", A_DATA, 32'h0);

    // CLKDIV=3 with a CTRL write mid-frame
    ahb_write(A_CTRL, 32'h301);
    b0 = busy_cyc; e0 = edges;
    send(8'h5A, 8'h5A, 1'b1);
    wait_start(20);
    repeat (10) @(negedge HCLK);
    ahb_write(A_CTRL, 32'h001);
    wait_end(200);
    check_eq("div3_half_period", last_gap, 32'd4);
    check_eq("div3_cycles", busy_cyc - b0, 32'd66);
    check_eq("div3_edges", edges - e0, 32'd16);
    check_eq("div3_mosi", {24'h0, mosi_hist[7:0]}, 32'h5A);
    read_data_sb();

    // Reset in the middle of a shift
    ahb_write(A_CTRL, 32'h301);
    send(8'hFF, 8'hFF, 1'b0);
    wait_start(20);
    repeat (6) @(negedge HCLK);
    HRESET = 1'b1;
    #1;
    check_eq("abort_ss", 32'(SPI_SS_o), 32'hF);
    check_eq("abort_sclk", 32'(SPI_CLK_o), 32'd0);
    check_eq("abort_mosi", 32'(SPI_MOSI_o), 32'd0);
    check_eq("abort_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    read_check("abort_data", A_DATA, 32'h0);
    read_check("abort_status", A_STATUS, 32'h05);
    read_check("abort_ctrl", A_CTRL, 32'h0);
    check_eq("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
